reimu_life_ctrl: RTL

//   Consumes the boss-bullet hit flag (shot) and owns the player's life count.

---
 rtl/touhou_pkg.sv | 34 +++
 rtl/reimu_life_ctrl_if.sv | 44 ++++
 rtl/reimu_life_ctrl_iframe_timer.sv | 40 ++++
 rtl/reimu_life_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/touhou_pkg.sv
// Shared game-wide definitions for the player life controller and the renderer.
// No ports. Provides:
//   life_state_t      - life controller FSM states
//   LIVES_W           - width of the lives count
//   *_DEF constants   - default life and invulnerability timing values
//   lives_dec/inc     - non-wrapping lives arithmetic
package touhou_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIVE,
        HIT,
        INVULN,
        DEAD
    } life_state_t;

    localparam int LIVES_W          = 3;
    localparam int LIVES_INIT_DEF   = 3;
    localparam int MAX_LIVES_DEF    = 5;
    localparam int IFRAME_TICKS_DEF = 48;
    localparam int BLINK_DIV_DEF    = 4;

    // Decrement that holds at zero so lives can never wrap to 7.
    function automatic logic [LIVES_W-1:0] lives_dec(input logic [LIVES_W-1:0] l);
        return (l == '0) ? '0 : l - LIVES_W'(1);
    endfunction

    // Increment that saturates at the given ceiling.
    function automatic logic [LIVES_W-1:0] lives_inc(input logic [LIVES_W-1:0] l,
                                                     input logic [LIVES_W-1:0] max_l);
        return (l >= max_l) ? max_l : l + LIVES_W'(1);
    endfunction

endpackage

// File: rtl/reimu_life_ctrl_if.sv
// Signal bundle between the game side (bullet stage, game FSM, score logic,
// renderer) and the player life controller.
//   start, shot, extend   : game side -> controller
//   lives, invincible,
//   blink, hit_pulse,
//   respawn, game_over    : controller -> game side
// Modports: master = game side, slave = reimu_life_ctrl.
// The extend signal only exists when LIFE_EXTEND_EN is defined.
interface reimu_life_ctrl_if;
    import touhou_pkg::*;

    logic               start;
    logic               shot;
`ifdef LIFE_EXTEND_EN
    logic               extend;
`endif
    logic [LIVES_W-1:0] lives;
    logic               invincible;
    logic               blink;
    logic               hit_pulse;
    logic               respawn;
    logic               game_over;

`ifdef LIFE_EXTEND_EN
    modport master (
        output start, shot, extend,
        input  lives, invincible, blink, hit_pulse, respawn, game_over
    );
    modport slave (
        input  start, shot, extend,
        output lives, invincible, blink, hit_pulse, respawn, game_over
    );
`else
    modport master (
        output start, shot,
        input  lives, invincible, blink, hit_pulse, respawn, game_over
    );
    modport slave (
        input  start, shot,
        output lives, invincible, blink, hit_pulse, respawn, game_over
    );
`endif

endinterface

// File: rtl/reimu_life_ctrl_iframe_timer.sv
// Loadable down-counter that times the invulnerability window.
//   clk22     in  game tick clock
//   rst       in  synchronous active-high reset, clears the count
//   load      in  load load_val on the next tick (wins over dec)
//   load_val  in  value to load
//   dec       in  count down by one, holding at zero
//   done      out count is zero
//   blink     out count bit TAP, the sprite-hide tap
// blink is a flop bit of the count, so it is a registered output, and it is
// zero whenever the counter has expired or been reset.
module iframe_timer #(
    parameter int WIDTH = 6,
    parameter int TAP   = 2
) (
    input  logic             clk22,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done,
    output logic             blink
);

    logic [WIDTH-1:0] count;

    // Count register: load takes priority, decrement stops at zero.
    always_ff @(posedge clk22) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done  = (count == '0);
    assign blink = count[TAP];

endmodule

// File: rtl/reimu_life_ctrl.sv
// Player life controller: owns the lives count, runs the post-hit
// invulnerability window with sprite blink, requests a respawn after each
// non-fatal hit and flags game over.
//   clk22  in   game tick clock
//   rst    in   synchronous active-high reset
//   bus    slave modport of reimu_life_ctrl_if
//            start (rising edge starts play from IDLE or DEAD), shot,
//            extend (LIFE_EXTEND_EN only), lives, invincible, blink,
//            hit_pulse, respawn, game_over
// Optional feature macro: LIFE_EXTEND_EN enables the extra-life input.
// All outputs come straight from flops.
module reimu_life_ctrl
    import touhou_pkg::*;
#(
    parameter int LIVES_INIT   = LIVES_INIT_DEF,
    parameter int MAX_LIVES    = MAX_LIVES_DEF,
    parameter int IFRAME_TICKS = IFRAME_TICKS_DEF,
    parameter int BLINK_DIV    = BLINK_DIV_DEF
) (
    input logic              clk22,
    input logic              rst,
    reimu_life_ctrl_if.slave bus
);

    // Timer must hold IFRAME_TICKS-1; the blink tap must sit inside it.
    localparam int TMR_W = $clog2(IFRAME_TICKS);
    localparam int TAP   = $clog2(BLINK_DIV);

    localparam logic [LIVES_W-1:0] INIT_L   = LIVES_W'(LIVES_INIT);
    localparam logic [LIVES_W-1:0] MAX_L    = LIVES_W'(MAX_LIVES);
    localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(IFRAME_TICKS - 1);

    life_state_t        state, state_nxt;
    logic [LIVES_W-1:0] lives, lives_nxt, net_lives;
    logic               game_over, game_over_nxt;
    logic               hit_pulse, hit_pulse_nxt;
    logic               respawn, respawn_nxt;
    logic               invincible, invincible_nxt;
    logic               start_q, start_rise;
    logic               ext;
    logic               tmr_load, tmr_dec, tmr_done, tmr_blink;

    assign start_rise = bus.start & ~start_q;

`ifdef LIFE_EXTEND_EN
    assign ext = bus.extend;
`else
    assign ext = 1'b0;
`endif

    iframe_timer #(
        .WIDTH (TMR_W),
        .TAP   (TAP)
    ) u_iframe_timer (
        .clk22    (clk22),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TMR_LOAD),
        .dec      (tmr_dec),
        .done     (tmr_done),
        .blink    (tmr_blink)
    );

    // State, lives, output flags and the start edge detector.
    always_ff @(posedge clk22) begin
        if (rst) begin
            state      <= IDLE;
            lives      <= INIT_L;
            game_over  <= 1'b0;
            hit_pulse  <= 1'b0;
            respawn    <= 1'b0;
            invincible <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            lives      <= lives_nxt;
            game_over  <= game_over_nxt;
            hit_pulse  <= hit_pulse_nxt;
            respawn    <= respawn_nxt;
            invincible <= invincible_nxt;
            start_q    <= bus.start;
        end
    end

    // Next-state logic. Output flags are computed for the state being
    // entered so that the registered outputs line up with that state.
    always_comb begin
        state_nxt      = state;
        lives_nxt      = lives;
        game_over_nxt  = game_over;
        hit_pulse_nxt  = 1'b0;
        respawn_nxt    = 1'b0;
        invincible_nxt = 1'b0;
        tmr_load       = 1'b0;
        tmr_dec        = 1'b0;

        // A shot and an extra life on the same tick net out; death is
        // decided on this combined value, decrement first then saturate.
        net_lives = lives_dec(lives);
        if (ext) begin
            net_lives = lives_inc(net_lives, MAX_L);
        end

        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_nxt = ALIVE;
                    lives_nxt = INIT_L;
                end
            end

            ALIVE: begin
                if (bus.shot) begin
                    lives_nxt = net_lives;
                    if (net_lives == '0) begin
                        state_nxt     = DEAD;
                        game_over_nxt = 1'b1;
                    end else begin
                        state_nxt      = HIT;
                        hit_pulse_nxt  = 1'b1;
                        respawn_nxt    = 1'b1;
                        invincible_nxt = 1'b1;
                    end
                end else if (ext) begin
                    lives_nxt = lives_inc(lives, MAX_L);
                end
            end

            HIT: begin
                state_nxt      = INVULN;
                tmr_load       = 1'b1;
                invincible_nxt = 1'b1;
                if (ext) begin
                    lives_nxt = lives_inc(lives, MAX_L);
                end
            end

            INVULN: begin
                if (ext) begin
                    lives_nxt = lives_inc(lives, MAX_L);
                end
                if (tmr_done) begin
                    state_nxt = ALIVE;
                end else begin
                    tmr_dec        = 1'b1;
                    invincible_nxt = 1'b1;
                end
            end

            DEAD: begin
                lives_nxt     = '0;
                game_over_nxt = 1'b1;
                if (start_rise) begin
                    state_nxt     = ALIVE;
                    lives_nxt     = INIT_L;
                    game_over_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.lives      = lives;
    assign bus.game_over  = game_over;
    assign bus.hit_pulse  = hit_pulse;
    assign bus.respawn    = respawn;
    assign bus.invincible = invincible;
    assign bus.blink      = tmr_blink;

endmodule
